strike_scheduler: RTL and testbench

Parametrised successor of the ball-triggered paddle-strike timer in the top level. It arms when the filtered ball state crosses a trigger line moving toward our goal, and computes the strike delay as ball delay minus paddle delay minus fixed latency, floored and clamped. It then fires a timed active-low strike pulse and enforces a holdoff before re-arming. It adds selectable approach direction, cancellation on abort or velocity reversal, and status counters. It sits between the Kalman/ball-delay logic and the stepper controller's i_Start input.

---
 rtl/strike_scheduler_if.sv | 28 ++
 rtl/strike_scheduler.sv | 125 ++++++++++++
 tb/tb_strike_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/strike_scheduler_if.sv
// Ball-state inputs and strike/status outputs of the strike scheduler.
// The scheduler takes the slave side; the ball-tracking logic or a test harness takes the master side.
interface strike_scheduler_if #(
    parameter int POS_W   = 16,
    parameter int DELAY_W = 32
) ();
    logic               i_enable;
    logic [POS_W-1:0]   i_x;
    logic [POS_W-1:0]   i_vx;
    logic [DELAY_W-1:0] i_ball_delay;
    logic [DELAY_W-1:0] i_paddle_delay;
    logic               i_abort;
    logic               o_strike_n;
    logic [3:0]         o_state;
    logic [DELAY_W-1:0] o_applied_delay;
    logic [7:0]         o_strike_count;
    logic               o_cancelled;

    modport slave (
        input  i_enable, i_x, i_vx, i_ball_delay, i_paddle_delay, i_abort,
        output o_strike_n, o_state, o_applied_delay, o_strike_count, o_cancelled
    );

    modport master (
        output i_enable, i_x, i_vx, i_ball_delay, i_paddle_delay, i_abort,
        input  o_strike_n, o_state, o_applied_delay, o_strike_count, o_cancelled
    );
endinterface

// File: rtl/strike_scheduler.sv
// Arms on a ball crossing the trigger line toward our goal, waits the clamped
// ball-minus-paddle delay, fires an active-low strike pulse, then holds off.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for an approaching ball with arming enabled
// S_DELAY   | counting down the latched delay; cancellable
// S_STRIKE  | o_strike_n low for PULSE_LEN cycles; not cancellable
// S_HOLDOFF | re-arm blocked for HOLDOFF cycles or until abort
module strike_scheduler #(
    parameter int POS_W        = 16,
    parameter int DELAY_W      = 32,
    parameter int TRIG_X       = 300,
    parameter int APPROACH_NEG = 1,
    parameter int FIXED_LAT    = 2500000,
    parameter int MIN_DELAY    = 1000,
    parameter int MAX_DELAY    = 49999999,
    parameter int PULSE_LEN    = 8,
    parameter int HOLDOFF      = 50000000
) (
    input  logic              i_clk_50,
    input  logic              i_reset_n,
    strike_scheduler_if.slave bus
);
    localparam int CALC_W = DELAY_W + 2;
    localparam logic [POS_W-1:0]   TRIG_POS   = POS_W'(TRIG_X);
    localparam logic [DELAY_W-1:0] PULSE_LAST = DELAY_W'(PULSE_LEN - 1);
    localparam logic [DELAY_W-1:0] HOLD_LAST  = DELAY_W'(HOLDOFF - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_DELAY   = 4'b0010,
        S_STRIKE  = 4'b0100,
        S_HOLDOFF = 4'b1000
    } state_t;

    state_t               stateReg;
    logic [DELAY_W-1:0]   counter;
    logic signed [CALC_W-1:0] rawDelay;
    logic [DELAY_W-1:0]   clampedDelay;
    logic [DELAY_W-1:0]   delayLast;
    logic                 vxNeg;
    logic                 vxPos;
    logic                 approach;

    // Two extra bits keep the subtraction from wrapping for any input pair.
    assign rawDelay = $signed({2'b00, bus.i_ball_delay}) - $signed({2'b00, bus.i_paddle_delay})
                      - CALC_W'(FIXED_LAT);

    always_comb begin
        clampedDelay = rawDelay[DELAY_W-1:0];
        if (rawDelay < CALC_W'(MIN_DELAY))
            clampedDelay = DELAY_W'(MIN_DELAY);
        else if (rawDelay > CALC_W'(MAX_DELAY))
            clampedDelay = DELAY_W'(MAX_DELAY);
    end

    assign vxNeg    = bus.i_vx[POS_W-1];
    assign vxPos    = !bus.i_vx[POS_W-1] && (bus.i_vx != '0);
    assign approach = (APPROACH_NEG != 0) ? (vxNeg && (bus.i_x < TRIG_POS))
                                          : (vxPos && (bus.i_x > TRIG_POS));

    assign delayLast   = bus.o_applied_delay - DELAY_W'(1);
    assign bus.o_state = stateReg;

    always_ff @(posedge i_clk_50) begin
        if (!i_reset_n) begin
            stateReg            <= S_IDLE;
            counter             <= '0;
            bus.o_strike_n      <= 1'b1;
            bus.o_applied_delay <= '0;
            bus.o_strike_count  <= '0;
            bus.o_cancelled     <= 1'b0;
        end else begin
            bus.o_cancelled <= 1'b0;
            case (stateReg)
                S_IDLE: begin
                    bus.o_strike_n <= 1'b1;
                    if (bus.i_enable && approach && !bus.i_abort) begin
                        bus.o_applied_delay <= clampedDelay;
                        counter             <= '0;
                        stateReg            <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (bus.i_abort || !bus.i_enable || !approach) begin
                        stateReg        <= S_IDLE;
                        bus.o_cancelled <= 1'b1;
                    end else if (counter == delayLast) begin
                        stateReg       <= S_STRIKE;
                        counter        <= '0;
                        bus.o_strike_n <= 1'b0;
                        if (bus.o_strike_count != 8'hFF)
                            bus.o_strike_count <= bus.o_strike_count + 8'd1;
                    end else begin
                        counter <= counter + DELAY_W'(1);
                    end
                end
                S_STRIKE: begin
                    if (counter == PULSE_LAST) begin
                        stateReg       <= S_HOLDOFF;
                        counter        <= '0;
                        bus.o_strike_n <= 1'b1;
                    end else begin
                        counter <= counter + DELAY_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    bus.o_strike_n <= 1'b1;
                    if (bus.i_abort || (counter == HOLD_LAST)) begin
                        stateReg <= S_IDLE;
                        counter  <= '0;
                    end else begin
                        counter <= counter + DELAY_W'(1);
                    end
                end
                default: begin
                    stateReg       <= S_IDLE;
                    counter        <= '0;
                    bus.o_strike_n <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_strike_scheduler.sv
// Directed bench for strike_scheduler: stimulus queues expected strike/cancel
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_strike_scheduler;
    localparam int POS_W   = 16;
    localparam int DELAY_W = 32;

    logic clk50  = 1'b0;
    logic resetN = 1'b0;
    always #10 clk50 = ~clk50;

    strike_scheduler_if #(.POS_W(POS_W), .DELAY_W(DELAY_W)) busNeg ();
    strike_scheduler_if #(.POS_W(POS_W), .DELAY_W(DELAY_W)) busPos ();

    strike_scheduler #(
        .POS_W(POS_W), .DELAY_W(DELAY_W), .TRIG_X(300), .APPROACH_NEG(1),
        .FIXED_LAT(100), .MIN_DELAY(10), .MAX_DELAY(1000), .PULSE_LEN(8), .HOLDOFF(50)
    ) dutNeg (
        .i_clk_50 (clk50),
        .i_reset_n(resetN),
        .bus      (busNeg)
    );

    strike_scheduler #(
        .POS_W(POS_W), .DELAY_W(DELAY_W), .TRIG_X(300), .APPROACH_NEG(0),
        .FIXED_LAT(100), .MIN_DELAY(10), .MAX_DELAY(1000), .PULSE_LEN(8), .HOLDOFF(50)
    ) dutPos (
        .i_clk_50 (clk50),
        .i_reset_n(resetN),
        .bus      (busPos)
    );

    int cycleNum = 0;
    always @(posedge clk50) cycleNum <= cycleNum + 1;

    int compared   = 0;
    int mismatched = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cycleNum);
        end
    endfunction

    typedef struct {
        bit     isCancel;
        int     cyc;
        int     len;
        longint dly;
        int     cnt;
    } ev_t;
    ev_t expQ[$];

    task automatic pushStrike(input int start, input int len, input int dly, input int cnt);
        ev_t e;
        e.isCancel = 1'b0; e.cyc = start; e.len = len; e.dly = longint'(dly); e.cnt = cnt;
        expQ.push_back(e);
    endtask

    task automatic pushCancel(input int cyc);
        ev_t e;
        e.isCancel = 1'b1; e.cyc = cyc; e.len = 0; e.dly = 0; e.cnt = 0;
        expQ.push_back(e);
    endtask

    logic   prevN    = 1'b1;
    int     startCyc = 0;
    longint startDly = 0;
    int     startCnt = 0;
    ev_t    mon;

    always @(negedge clk50) begin
        if (prevN === 1'b1 && busNeg.o_strike_n === 1'b0) begin
            startCyc = cycleNum;
            startDly = longint'(busNeg.o_applied_delay);
            startCnt = int'(busNeg.o_strike_count);
        end
        if (prevN === 1'b0 && busNeg.o_strike_n === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_strike: got strike at cycle %0d, want none", startCyc);
            end else begin
                mon = expQ.pop_front();
                check("event_kind_strike", 64'(0), 64'(mon.isCancel));
                check("strike_start", 64'(startCyc), 64'(mon.cyc));
                check("strike_len", 64'(cycleNum - startCyc), 64'(mon.len));
                check("strike_delay", 64'(startDly), 64'(mon.dly));
                check("strike_count", 64'(startCnt), 64'(mon.cnt));
            end
        end
        if (busNeg.o_cancelled === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_cancel: got cancel at cycle %0d, want none", cycleNum);
            end else begin
                mon = expQ.pop_front();
                check("event_kind_cancel", 64'(1), 64'(mon.isCancel));
                check("cancel_cycle", 64'(cycleNum), 64'(mon.cyc));
            end
        end
        prevN = busNeg.o_strike_n;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic drive(input logic en, input int x, input int vx, input int ball,
                         input int paddle, input logic abort);
        busNeg.i_enable       = en;
        busNeg.i_x            = 16'(x);
        busNeg.i_vx           = 16'(vx);
        busNeg.i_ball_delay   = 32'(ball);
        busNeg.i_paddle_delay = 32'(paddle);
        busNeg.i_abort        = abort;
    endtask

    int tblBall[9]   = '{1100, 1101, 110, 109, 111, 0,    150, -1, 0};
    int tblPaddle[9] = '{0,    0,    0,   0,   0,   5000, 40,  0,  -1};
    int tblD[9]      = '{1000, 1000, 10,  10,  11,  10,   10,  1000, 10};

    int t0;

    initial begin
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        busPos.i_enable = 1'b0; busPos.i_x = '0; busPos.i_vx = '0;
        busPos.i_ball_delay = '0; busPos.i_paddle_delay = '0; busPos.i_abort = 1'b0;

        // reset state
        tick(3);
        check("rst_state", 64'(busNeg.o_state), 64'(4'b0001));
        check("rst_strike_n", 64'(busNeg.o_strike_n), 64'(1));
        check("rst_applied", 64'(busNeg.o_applied_delay), 64'(0));
        check("rst_count", 64'(busNeg.o_strike_count), 64'(0));
        check("rst_cancelled", 64'(busNeg.o_cancelled), 64'(0));
        resetN = 1'b1;
        tick(1);

        // nominal strike, full holdoff, trigger held true throughout
        drive(1'b1, 250, -5, 500, 200, 1'b0);
        t0 = cycleNum;
        pushStrike(t0 + 201, 8, 200, 1);
        tick(1);
        check("t1_state_delay", 64'(busNeg.o_state), 64'(4'b0010));
        check("t1_applied", 64'(busNeg.o_applied_delay), 64'(200));
        tick(199);
        check("t1_last_delay", 64'(busNeg.o_state), 64'(4'b0010));
        tick(9);
        check("t1_holdoff", 64'(busNeg.o_state), 64'(4'b1000));
        check("t1_count", 64'(busNeg.o_strike_count), 64'(1));
        tick(49);
        check("t1_holdoff_end", 64'(busNeg.o_state), 64'(4'b1000));
        tick(1);
        check("t1_idle", 64'(busNeg.o_state), 64'(4'b0001));
        drive(1'b0, 250, -5, 500, 200, 1'b0);
        tick(1);

        // floored delay, abort in holdoff
        drive(1'b1, 250, -5, 250, 200, 1'b0);
        t0 = cycleNum;
        pushStrike(t0 + 11, 8, 10, 2);
        tick(1);
        check("t2_applied_min", 64'(busNeg.o_applied_delay), 64'(10));
        tick(18);
        check("t2_holdoff", 64'(busNeg.o_state), 64'(4'b1000));
        busNeg.i_abort = 1'b1;
        tick(1);
        check("t2_abort_holdoff", 64'(busNeg.o_state), 64'(4'b0001));

        // clamped delay
        drive(1'b1, 250, -5, 5000, 0, 1'b0);
        t0 = cycleNum;
        pushStrike(t0 + 1001, 8, 1000, 3);
        tick(1);
        check("t2_applied_max", 64'(busNeg.o_applied_delay), 64'(1000));
        tick(1008);
        check("t2_holdoff2", 64'(busNeg.o_state), 64'(4'b1000));
        busNeg.i_abort = 1'b1;
        tick(1);
        drive(1'b0, 250, -5, 0, 0, 1'b0);
        tick(1);

        // delay calculation boundaries, each arm cancelled by abort
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 250, -5, tblBall[i], tblPaddle[i], 1'b0);
            tick(1);
            check("tbl_applied", 64'(busNeg.o_applied_delay), 64'(tblD[i]));
            busNeg.i_abort = 1'b1;
            pushCancel(cycleNum + 1);
            tick(1);
            busNeg.i_abort = 1'b0;
        end
        drive(1'b0, 250, -5, 0, 0, 1'b0);
        tick(1);

        // cancel by velocity reversal
        drive(1'b1, 250, -5, 500, 200, 1'b0);
        tick(50);
        busNeg.i_vx = 16'(3);
        pushCancel(cycleNum + 1);
        tick(1);
        check("t3_vx_idle", 64'(busNeg.o_state), 64'(4'b0001));
        check("t3_vx_count", 64'(busNeg.o_strike_count), 64'(3));
        busNeg.i_enable = 1'b0;
        tick(1);

        // cancel by abort mid-delay
        drive(1'b1, 250, -5, 500, 200, 1'b0);
        tick(50);
        busNeg.i_abort = 1'b1;
        pushCancel(cycleNum + 1);
        tick(1);
        check("t3_abort_idle", 64'(busNeg.o_state), 64'(4'b0001));
        drive(1'b0, 250, -5, 500, 200, 1'b0);
        tick(1);

        // abort coinciding with terminal count
        drive(1'b1, 250, -5, 500, 200, 1'b0);
        tick(200);
        busNeg.i_abort = 1'b1;
        pushCancel(cycleNum + 1);
        tick(1);
        check("t3_tc_idle", 64'(busNeg.o_state), 64'(4'b0001));
        check("t3_tc_strike_n", 64'(busNeg.o_strike_n), 64'(1));
        check("t3_tc_count", 64'(busNeg.o_strike_count), 64'(3));
        drive(1'b0, 250, -5, 500, 200, 1'b0);
        tick(1);

        // positive-approach instance
        busPos.i_enable = 1'b1; busPos.i_x = 16'(400); busPos.i_vx = 16'(5);
        busPos.i_ball_delay = 32'(500); busPos.i_paddle_delay = 32'(200);
        tick(1);
        check("t4_pos_arm", 64'(busPos.o_state), 64'(4'b0010));
        check("t4_pos_applied", 64'(busPos.o_applied_delay), 64'(200));
        busPos.i_abort = 1'b1;
        tick(1);
        check("t4_pos_cancel_state", 64'(busPos.o_state), 64'(4'b0001));
        check("t4_pos_cancelled", 64'(busPos.o_cancelled), 64'(1));
        busPos.i_abort = 1'b0; busPos.i_x = 16'(250); busPos.i_vx = 16'(-5);
        tick(2);
        check("t4_pos_wrong_dir", 64'(busPos.o_state), 64'(4'b0001));
        busPos.i_x = 16'(400); busPos.i_vx = 16'(0);
        tick(2);
        check("t4_pos_vx0", 64'(busPos.o_state), 64'(4'b0001));
        busPos.i_x = 16'(300); busPos.i_vx = 16'(5);
        tick(2);
        check("t4_pos_on_line", 64'(busPos.o_state), 64'(4'b0001));
        busPos.i_enable = 1'b0;

        // negative-approach boundaries
        drive(1'b1, 300, -5, 500, 200, 1'b0);
        tick(2);
        check("t4_neg_on_line", 64'(busNeg.o_state), 64'(4'b0001));
        drive(1'b1, 250, 0, 500, 200, 1'b0);
        tick(2);
        check("t4_neg_vx0", 64'(busNeg.o_state), 64'(4'b0001));
        drive(1'b0, 250, -5, 500, 200, 1'b0);
        tick(1);

        // reset on the third strike cycle
        drive(1'b1, 250, -5, 250, 200, 1'b0);
        t0 = cycleNum;
        pushStrike(t0 + 11, 3, 10, 4);
        tick(13);
        check("t5_strike_low", 64'(busNeg.o_strike_n), 64'(0));
        resetN = 1'b0;
        busNeg.i_enable = 1'b0;
        tick(1);
        check("t5_rst_strike_n", 64'(busNeg.o_strike_n), 64'(1));
        check("t5_rst_state", 64'(busNeg.o_state), 64'(4'b0001));
        check("t5_rst_count", 64'(busNeg.o_strike_count), 64'(0));
        check("t5_rst_applied", 64'(busNeg.o_applied_delay), 64'(0));
        resetN = 1'b1;
        tick(1);

        // 260 back-to-back strikes, counter saturates
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 250, -5, 250, 200, 1'b0);
            t0 = cycleNum;
            pushStrike(t0 + 11, 8, 10, (i + 1 > 255) ? 255 : i + 1);
            tick(19);
            busNeg.i_abort = 1'b1;
            tick(1);
        end
        drive(1'b0, 250, -5, 0, 0, 1'b0);
        tick(1);
        check("t6_saturated", 64'(busNeg.o_strike_count), 64'(255));

        tick(5);
        check("queue_drained", 64'(expQ.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
